// File: rtl/adc_scan_pkg.sv
// Shared constants and state type for the ADC scan controller.
// Frame timing: address bits go out at cnt 2..4, result bits arrive at cnt 4..15.
package adc_scan_pkg;

    localparam int FRAME_LEN = 16;
    localparam int ADC_RES   = 12;

    localparam logic [3:0] ADDR2_CNT      = 4'd2;
    localparam logic [3:0] ADDR1_CNT      = 4'd3;
    localparam logic [3:0] ADDR0_CNT      = 4'd4;
    localparam logic [3:0] DATA_FIRST_CNT = 4'd4;
    localparam logic [3:0] DATA_LAST_CNT  = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } scan_state_t;

endpackage

// File: rtl/adc_ch_sel.sv
// Next-channel picker: the lowest set mask bit strictly above cur, else the
// lowest set bit overall. Passing cur = 7 therefore yields the first channel.
module adc_ch_sel #(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [2:0]        cur,
    output logic [2:0]        next
);

    logic [2:0] lowest;
    logic [2:0] above;
    logic       has_above;

    // Scanning downward leaves the smallest qualifying index in each result.
    always_comb begin
        lowest    = 3'd0;
        above     = 3'd0;
        has_above = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = 3'(i);
                if (3'(i) > cur) begin
                    above     = 3'(i);
                    has_above = 1'b1;
                end
            end
        end
        next = has_above ? above : lowest;
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan controller for a 16-clock serial ADC with a per-channel result bank.
// Define ADC_SCAN_AVG_EN to turn bank updates into a 1/4-weight running average.
module adc_scan_ctrl #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              din,
    output logic              dout,
    output logic              csn,
    output logic              smp_stb,
    output logic [2:0]        smp_ch,
    output logic [DATA_W-1:0] smp_data
);

    import adc_scan_pkg::*;

    scan_state_t         state;
    logic [3:0]          cnt;
    logic [2:0]          cur_ch;
    logic [2:0]          prev_ch;
    logic [ADC_RES-2:0]  shift;
    logic [DATA_W-1:0]   bank [NUM_CH];
    logic [NUM_CH-1:0]   valid;

    logic                mask_any;
    logic [2:0]          sel_cur;
    logic [2:0]          next_ch;
    logic [ADC_RES-1:0]  word;
    logic [DATA_W-1:0]   x;
    logic [DATA_W-1:0]   new_val;

    assign mask_any = |ch_mask;
    assign sel_cur  = (state == IDLE) ? 3'd7 : cur_ch;

    adc_ch_sel #(
        .NUM_CH (NUM_CH)
    ) u_ch_sel (
        .mask (ch_mask),
        .cur  (sel_cur),
        .next (next_ch)
    );

    // The shift register holds the first 11 bits; the last one is taken live from din.
    assign word = {shift, din};
    assign x    = word[ADC_RES-1 -: DATA_W];

`ifdef ADC_SCAN_AVG_EN
    logic [DATA_W-1:0]        bank_prev;
    logic                     prev_valid;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W:0]   step;
    logic [DATA_W-1:0]        avg;

    always_comb begin
        bank_prev  = '0;
        prev_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == prev_ch) begin
                bank_prev  = bank[i];
                prev_valid = valid[i];
            end
        end
    end

    // Result always lies between old and new sample, so truncation cannot wrap.
    assign diff    = $signed({1'b0, x}) - $signed({1'b0, bank_prev});
    assign step    = diff >>> 2;
    assign avg     = DATA_W'($unsigned({1'b0, bank_prev}) + $unsigned(step));
    assign new_val = prev_valid ? avg : x;
`else
    assign new_val = x;
`endif

    assign csn = (state == IDLE);

    always_comb begin
        dout = 1'b0;
        if (cnt == ADDR2_CNT) begin
            dout = cur_ch[2];
        end else if (cnt == ADDR1_CNT) begin
            dout = cur_ch[1];
        end else if (cnt == ADDR0_CNT) begin
            dout = cur_ch[0];
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == rd_addr) begin
                rd_data  = bank[i];
                rd_valid = valid[i];
            end
        end
    end

    // Data arriving in a frame belongs to the channel addressed one frame earlier,
    // so the PRIME frame only addresses and RUN frames store for prev_ch.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_ch   <= '0;
            prev_ch  <= '0;
            shift    <= '0;
            smp_stb  <= 1'b0;
            smp_ch   <= '0;
            smp_data <= '0;
            valid    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            smp_stb <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en && mask_any) begin
                        state  <= PRIME;
                        cur_ch <= next_ch;
                    end
                end
                PRIME, RUN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt >= DATA_FIRST_CNT) begin
                        shift <= word[ADC_RES-2:0];
                    end
                    if (cnt == DATA_LAST_CNT) begin
                        prev_ch <= cur_ch;
                        if (mask_any) begin
                            cur_ch <= next_ch;
                        end
                        if (state == RUN) begin
                            smp_stb  <= 1'b1;
                            smp_ch   <= prev_ch;
                            smp_data <= new_val;
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (3'(i) == prev_ch) begin
                                    bank[i]  <= new_val;
                                    valid[i] <= 1'b1;
                                end
                            end
                            if (!en || !mask_any) begin
                                state <= IDLE;
                            end
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: an ADC model plus a frame-level reference
// model; directed tables and sequences followed by a randomized scan run.
module tb_adc_scan_ctrl;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 12;

    logic              sclk = 1'b0;
    logic              rst;
    logic              en;
    logic [NUM_CH-1:0] ch_mask;
    logic [2:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              din;
    logic              dout;
    logic              csn;
    logic              smp_stb;
    logic [2:0]        smp_ch;
    logic [DATA_W-1:0] smp_data;

    adc_scan_ctrl #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) dut (
        .sclk     (sclk),
        .rst      (rst),
        .en       (en),
        .ch_mask  (ch_mask),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .din      (din),
        .dout     (dout),
        .csn      (csn),
        .smp_stb  (smp_stb),
        .smp_ch   (smp_ch),
        .smp_data (smp_data)
    );

    always #5 sclk = ~sclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: scanning flag, priming flag, frame position, channels, bank.
    bit                m_active;
    bit                m_prime;
    int                m_pos;
    int                m_cur;
    int                m_prev;
    bit                m_stb;
    int                m_stb_ch;
    logic [DATA_W-1:0] m_stb_data;
    logic [DATA_W-1:0] m_bank [NUM_CH];
    bit                m_valid [NUM_CH];

    // ADC model: decodes the address from dout and answers one frame later.
    bit                adc_fixed;
    logic [11:0]       adc_fixed_val [8];
    logic [11:0]       adc_frame_val;
    logic [2:0]        adc_addr_cur;
    logic [2:0]        adc_addr_prev;
    int                addr_q [$];

    int                cyc;
    int                stb_at_q [$];
    int                stb_ch_q [$];
    int                stb_data_q [$];

    typedef struct {
        logic [7:0] mask;
        logic [2:0] first_ch;
        logic [2:0] second_ch;
    } vec_t;

    vec_t vecs [8];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lowest_set(input logic [NUM_CH-1:0] m);
        for (int k = 0; k < NUM_CH; k++) begin
            if (m[k]) return k;
        end
        return 0;
    endfunction

    function automatic int next_set(input logic [NUM_CH-1:0] m, input int c);
        for (int s = 1; s <= NUM_CH; s++) begin
            if (m[(c + s) % NUM_CH]) return (c + s) % NUM_CH;
        end
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] model_store(input int ch, input logic [DATA_W-1:0] xv);
`ifdef ADC_SCAN_AVG_EN
        int b;
        int d;
        if (!m_valid[ch]) return xv;
        b = int'(m_bank[ch]);
        d = int'(xv) - b;
        return DATA_W'(b + (d >>> 2));
`else
        return xv;
`endif
    endfunction

    task automatic model_reset();
        m_active      = 1'b0;
        m_prime       = 1'b0;
        m_pos         = 0;
        m_cur         = 0;
        m_prev        = 0;
        m_stb         = 1'b0;
        m_stb_ch      = 0;
        m_stb_data    = '0;
        adc_addr_cur  = '0;
        adc_addr_prev = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_bank[k]  = '0;
            m_valid[k] = 1'b0;
        end
    endtask

    task automatic clear_logs();
        addr_q.delete();
        stb_at_q.delete();
        stb_ch_q.delete();
        stb_data_q.delete();
        cyc = 0;
    endtask

    // One clock: ADC drives din and the read port is checked before the edge,
    // the model advances, then all outputs are compared after the edge.
    task automatic apply_stimulus();
        logic [DATA_W-1:0] xv;
        logic [DATA_W-1:0] nv;
        logic              exp_dout;
        if (m_active && m_pos == 0) begin
            adc_frame_val = adc_fixed ? adc_fixed_val[adc_addr_prev] : 12'($urandom);
        end
        if (m_active && m_pos >= 4) din = adc_frame_val[15 - m_pos];
        else                        din = 1'($urandom);
        rd_addr = 3'($urandom_range(0, 7));
        #1;
        check_output("rd_data", 32'(rd_data), 32'(m_bank[rd_addr]));
        check_output("rd_valid", 32'(rd_valid), 32'(m_valid[rd_addr]));

        m_stb = 1'b0;
        if (!rst) begin
            model_reset();
        end else if (!m_active) begin
            if (en && ch_mask != 0) begin
                m_active = 1'b1;
                m_prime  = 1'b1;
                m_pos    = 0;
                m_cur    = lowest_set(ch_mask);
            end
        end else begin
            if (m_pos == 15) begin
                if (!m_prime) begin
                    xv = adc_frame_val[11 -: DATA_W];
                    nv = model_store(m_prev, xv);
                    m_bank[m_prev]  = nv;
                    m_valid[m_prev] = 1'b1;
                    m_stb      = 1'b1;
                    m_stb_ch   = m_prev;
                    m_stb_data = nv;
                end
                m_prev = m_cur;
                if (ch_mask != 0) m_cur = next_set(ch_mask, m_cur);
                adc_addr_prev = adc_addr_cur;
                if (m_prime)                   m_prime  = 1'b0;
                else if (!en || ch_mask == 0)  m_active = 1'b0;
            end
            m_pos = (m_pos + 1) % 16;
        end

        @(negedge sclk);
        cyc++;
        exp_dout = 1'b0;
        if (m_active && m_pos >= 2 && m_pos <= 4) exp_dout = 1'((m_cur >> (4 - m_pos)) & 1);
        check_output("csn", 32'(csn), 32'(!m_active));
        check_output("dout", 32'(dout), 32'(exp_dout));
        check_output("smp_stb", 32'(smp_stb), 32'(m_stb));
        check_output("smp_ch", 32'(smp_ch), 32'(m_stb_ch));
        check_output("smp_data", 32'(smp_data), 32'(m_stb_data));
        if (m_active && m_pos >= 2 && m_pos <= 4) begin
            adc_addr_cur[4 - m_pos] = dout;
            if (m_pos == 4) addr_q.push_back(int'(adc_addr_cur));
        end
        if (smp_stb === 1'b1) begin
            stb_at_q.push_back(cyc);
            stb_ch_q.push_back(int'(smp_ch));
            stb_data_q.push_back(int'(smp_data));
        end
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        en      = 1'b0;
        ch_mask = '0;
        model_reset();
        repeat (2) apply_stimulus();
        rst = 1'b1;
        clear_logs();
    endtask

    initial begin
        int found;
        int csn_bad;
        int exp_at [3];
        int exp_ch [3];
        int exp_dat [3];
        int exp_avg [4];

        vecs[0] = '{8'h05, 3'd0, 3'd2};
        vecs[1] = '{8'h80, 3'd7, 3'd7};
        vecs[2] = '{8'h01, 3'd0, 3'd0};
        vecs[3] = '{8'h12, 3'd1, 3'd4};
        vecs[4] = '{8'hC0, 3'd6, 3'd7};
        vecs[5] = '{8'hFF, 3'd0, 3'd1};
        vecs[6] = '{8'h81, 3'd0, 3'd7};
        vecs[7] = '{8'h20, 3'd5, 3'd5};

        rst       = 1'b0;
        en        = 1'b0;
        ch_mask   = '0;
        din       = 1'b0;
        rd_addr   = 3'd3;
        adc_fixed = 1'b0;
        for (int k = 0; k < 8; k++) adc_fixed_val[k] = 12'($urandom);
        model_reset();
        clear_logs();

        // Reset values
        repeat (2) @(negedge sclk);
        #1;
        check_output("reset_csn", 32'(csn), 32'd1);
        check_output("reset_dout", 32'(dout), 32'd0);
        check_output("reset_smp_stb", 32'(smp_stb), 32'd0);
        check_output("reset_smp_ch", 32'(smp_ch), 32'd0);
        check_output("reset_smp_data", 32'(smp_data), 32'd0);
        check_output("reset_rd_valid", 32'(rd_valid), 32'd0);
        check_output("reset_rd_data", 32'(rd_data), 32'd0);
        @(negedge sclk);

        // Address sequence table: first two frames' addresses as seen on dout
        for (int v = 0; v < 8; v++) begin
            do_reset();
            ch_mask = vecs[v].mask;
            en      = 1'b1;
            repeat (36) apply_stimulus();
            check_output($sformatf("vec%0d_addr_count", v), 32'(addr_q.size()), 32'd2);
            if (addr_q.size() >= 2) begin
                check_output($sformatf("vec%0d_first_ch", v), 32'(addr_q[0]), 32'(vecs[v].first_ch));
                check_output($sformatf("vec%0d_second_ch", v), 32'(addr_q[1]), 32'(vecs[v].second_ch));
            end
        end

        // Two-channel scan with fixed ADC answers
        do_reset();
        adc_fixed        = 1'b1;
        adc_fixed_val[0] = 12'hA5C;
        adc_fixed_val[2] = 12'h3F0;
        ch_mask = 8'h05;
        en      = 1'b1;
        repeat (70) apply_stimulus();
        exp_at  = '{33, 49, 65};
        exp_ch  = '{0, 2, 0};
        exp_dat = '{12'hA5C, 12'h3F0, 12'hA5C};
        check_output("scan05_stb_count", 32'(stb_at_q.size()), 32'd3);
        for (int k = 0; k < 3 && k < stb_at_q.size(); k++) begin
            check_output($sformatf("scan05_stb%0d_cycle", k), 32'(stb_at_q[k]), 32'(exp_at[k]));
            check_output($sformatf("scan05_stb%0d_ch", k), 32'(stb_ch_q[k]), 32'(exp_ch[k]));
            check_output($sformatf("scan05_stb%0d_data", k), 32'(stb_data_q[k]), 32'(exp_dat[k]));
        end

        // Averaging behaviour: ch0 sees 0x000 once, then 0x400 forever
        do_reset();
        adc_fixed_val[0] = 12'h000;
        ch_mask = 8'h01;
        en      = 1'b1;
        for (int k = 0; k < 90; k++) begin
            apply_stimulus();
            if (stb_at_q.size() >= 1) adc_fixed_val[0] = 12'h400;
        end
`ifdef ADC_SCAN_AVG_EN
        exp_avg = '{12'h000, 12'h100, 12'h1C0, 12'h250};
`else
        exp_avg = '{12'h000, 12'h400, 12'h400, 12'h400};
`endif
        check_output("avg_stb_count", 32'(stb_at_q.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < stb_data_q.size(); k++) begin
            check_output($sformatf("avg_value%0d", k), 32'(stb_data_q[k]), 32'(exp_avg[k]));
        end
        adc_fixed = 1'b0;

        // en dropped at cnt 6 of a RUN frame: frame still completes and stores
        do_reset();
        ch_mask = 8'h01;
        en      = 1'b1;
        found   = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            apply_stimulus();
            if (m_active && !m_prime && m_pos == 6) found = 1;
        end
        check_output("endrop_reach_cnt6", 32'(found), 32'd1);
        en    = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            apply_stimulus();
            if (smp_stb === 1'b1) begin
                found = 1;
                check_output("endrop_csn_after_frame", 32'(csn), 32'd1);
            end
        end
        check_output("endrop_result_stored", 32'(found), 32'd1);

        // Reset at cnt 9 of the second RUN frame
        do_reset();
        ch_mask = 8'h01;
        en      = 1'b1;
        found   = 0;
        for (int k = 0; k < 80 && found == 0; k++) begin
            apply_stimulus();
            if (m_active && !m_prime && m_pos == 9 && stb_at_q.size() >= 1) found = 1;
        end
        check_output("rst_reach_cnt9", 32'(found), 32'd1);
        rst     = 1'b0;
        rd_addr = 3'd0;
        #1;
        check_output("rst_mid_csn", 32'(csn), 32'd1);
        check_output("rst_mid_dout", 32'(dout), 32'd0);
        check_output("rst_mid_smp_stb", 32'(smp_stb), 32'd0);
        check_output("rst_mid_smp_ch", 32'(smp_ch), 32'd0);
        check_output("rst_mid_smp_data", 32'(smp_data), 32'd0);
        check_output("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        check_output("rst_mid_rd_data", 32'(rd_data), 32'd0);
        model_reset();
        clear_logs();
        repeat (3) apply_stimulus();
        check_output("rst_no_stb", 32'(stb_at_q.size()), 32'd0);
        rst = 1'b1;
        clear_logs();
        repeat (40) apply_stimulus();
        check_output("rst_first_stb_cycle", 32'(stb_at_q.size() > 0 ? stb_at_q[0] : -1), 32'd33);

        // Empty mask never starts a scan
        do_reset();
        ch_mask = 8'h00;
        en      = 1'b1;
        csn_bad = 0;
        for (int k = 0; k < 100; k++) begin
            apply_stimulus();
            if (csn !== 1'b1) csn_bad++;
        end
        check_output("nomask_csn_low_cycles", 32'(csn_bad), 32'd0);
        check_output("nomask_stb_count", 32'(stb_at_q.size()), 32'd0);

        // Randomized run with mask and enable changes at arbitrary times
        do_reset();
        ch_mask = NUM_CH'($urandom);
        en      = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            apply_stimulus();
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 99) < 4) begin
                ch_mask = NUM_CH'($urandom);
                if ($urandom_range(0, 9) == 0) ch_mask = '0;
            end
            if (k == 1200) begin
                rst = 1'b0;
                model_reset();
                apply_stimulus();
                rst = 1'b1;
            end
        end
        check_output("random_some_results", 32'(stb_at_q.size() > 20), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8, number of scanned ADC inputs; legal range 1..8.
REQ-002 Parameter DATA_W, default 12, stored result width; legal range 8..12; the top DATA_W of the 12 ADC bits are kept.
REQ-003 sclk  input  1  ADC serial clock and sole block clock; all flops on posedge sclk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  scan enable.
REQ-006 ch_mask  input  NUM_CH  per-channel scan enable; bit i selects ADC input i.
REQ-007 rd_addr  input  3  result-bank read select.
REQ-008 rd_data  output  DATA_W  bank[rd_addr], combinational; 0 when rd_addr >= NUM_CH.
REQ-009 rd_valid  output  1  bank[rd_addr] written since reset.
REQ-010 din  input  1  serial data from the ADC.
REQ-011 dout  output  1  serial control word to the ADC.
REQ-012 csn  output  1  ADC chip select, active-low.
REQ-013 smp_stb  output  1  one-cycle pulse: new result stored.
REQ-014 smp_ch  output  3  channel of the result flagged by smp_stb.
REQ-015 smp_data  output  DATA_W  value just stored; held until the next smp_stb.

Function
REQ-016 Frame = 16 sclk cycles, 4-bit counter cnt 0..15, wraps 15->0 with no gap while running.
REQ-017 States IDLE, PRIME, RUN; csn = 1 in IDLE, 0 in PRIME and RUN.
REQ-018 IDLE->PRIME when en=1 and ch_mask != 0, sampled on any IDLE cycle; cnt = 0 on the first PRIME cycle.
REQ-019 PRIME->RUN at cnt=15; RUN->IDLE at cnt=15 when en=0 or ch_mask=0; en changes never truncate a frame.
REQ-020 dout = cur_ch[2] at cnt=2, cur_ch[1] at cnt=3, cur_ch[0] at cnt=4, else 0; combinational from cnt and cur_ch.
REQ-021 din is shifted MSB-first into a 12-bit register at cnt 4..15.
REQ-022 The ADC pipelines by one frame: the data in frame N belongs to the channel addressed in frame N-1 (prev_ch).
REQ-023 In PRIME, shifted data is discarded; no bank write and no smp_stb.
REQ-024 In RUN at cnt=15: word = {shift[10:0], din}; bank[prev_ch] updated from word[11 -: DATA_W]; valid[prev_ch] set; smp_stb high the next cycle; smp_ch = prev_ch, smp_data = new bank value.
REQ-025 At cnt=15: prev_ch <= cur_ch; cur_ch <= next set bit of ch_mask strictly above cur_ch, wrapping to the lowest set bit; single-bit mask repeats the same channel.
REQ-026 The first cur_ch on IDLE->PRIME is the lowest set bit of ch_mask.
REQ-027 ch_mask is sampled only at cnt=15 and on IDLE exit; mid-frame changes have no effect on the current frame.
REQ-028 When the mask change at cnt=15 removes prev_ch, that channel's result is still stored.
REQ-029 A read and a bank write of the same channel in the same cycle return the old value; the new value is visible the next cycle.

Reset
REQ-030 rst=0 forces immediately: state IDLE, cnt 0, csn 1, dout 0, smp_stb 0, smp_ch 0, smp_data 0, shift 0, cur_ch/prev_ch 0, all bank entries and valid bits 0.
REQ-031 Reset mid-frame abandons the frame; no partial result is stored.
REQ-032 After reset release, the next frame starts in PRIME.

Configuration
REQ-033 Macro ADC_SCAN_AVG_EN compiled in: bank[ch] <= bank[ch] + ((x - bank[ch]) >>> 2), where x = word[11 -: DATA_W]; difference computed signed in DATA_W+1 bits; result truncated to DATA_W, never wraps.
REQ-034 The first write after reset to a channel (valid=0) loads x directly, with or without the macro.
REQ-035 Without ADC_SCAN_AVG_EN: bank[ch] <= x; no averaging logic present.

Structure
REQ-036 Package adc_scan_pkg holds FRAME_LEN=16, ADC_RES=12, the address bit positions (2,3,4), the data window (4..15), and the state enum.
REQ-037 Sub-module adc_ch_sel: combinational next-channel priority encoder (mask, current -> next, with wrap); no other sub-modules.

Verification
REQ-038 ch_mask=8'h05, en=1, ADC model returns 12'hA5C for ch0 and 12'h3F0 for ch2 -> first smp_stb at the end of frame 2 with ch0/12'hA5C, then ch2/12'h3F0, alternating; dout bits 000 then 010.
REQ-039 ch_mask=8'h80 -> ch7 is addressed every frame; dout at cnt 2..4 = 1,1,1; bank[7] updates every 16 cycles.
REQ-040 en dropped at cnt=6 -> frame completes, result stored, csn=1 from the cycle after cnt=15.
REQ-041 rst asserted at cnt=9 -> csn=1 and all outputs 0 at once; no smp_stb; after release, first result at the end of the second frame.
REQ-042 ADC_SCAN_AVG_EN, ch0 fed 0x000 then constant 0x400 -> bank[0] = 0x000, 0x100, 0x1C0, 0x250.
REQ-043 ch_mask=0 with en=1 -> csn stays 1, no smp_stb for 100 cycles.
